// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART blocks.
//   rx_state_t : receiver FSM states (names mirror the transmitter's states)
//   clog2()    : minimum counter width able to hold values 0..value-1
//   par_calc() : parity of a zero-extended data word (even, or odd when odd=1)
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    // Width of a counter that must reach value-1; never narrower than 1 bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) width = i + 1;
        end
        return width;
    endfunction

    // Expected parity bit. Unused upper bits must be zero so they do not
    // disturb the reduction XOR.
    function automatic logic par_calc(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for an asynchronous, idle-high input.
// Both flops reset to 1 so a line in its idle state raises no event after reset.
// Ports:
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   i_async : asynchronous input
//   o_sync  : synchronized copy of i_async, two clocks later
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // NOTE: non-blocking assignments make both flops sample together; with
    // blocking ones the second flop would see the first one's new value and
    // the chain would collapse into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Oversampling UART receiver: start bit, DATA_WIDTH data bits LSB first,
// optional parity, STOP_BITS stop bits. Good frames are written to an external
// RX FIFO with a one-clock strobe; parity, framing, overrun and break are
// reported as one-clock pulses.
//
// Build option: define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote
// over three consecutive ticks (one tick later than the single-sample build).
//
// Ports:
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   sample_tick : one-clock pulse at OVERSAMPLE x baud
//   rx          : asynchronous serial line, idle high
//   fifo_full   : RX FIFO cannot accept a write
//   data_out    : last good word, held until the next good frame
//   data_write  : one-clock FIFO write strobe
//   rx_busy     : high whenever the receiver is not idle
//   parity_err  : one-clock pulse, parity mismatch on a written frame
//   frame_err   : one-clock pulse, a stop bit was sampled low
//   overrun_err : one-clock pulse, good frame dropped because fifo_full
//   break_det   : one-clock pulse, whole frame including stop bits was zero
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_tick,
    input  logic                  rx,
    input  logic                  fifo_full,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_write,
    output logic                  rx_busy,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  break_det
);

    localparam int TICK_W = clog2(OVERSAMPLE);
    localparam int BIT_W  = clog2(DATA_WIDTH + 1);

    // The start bit is judged near mid-bit; every later bit is judged a full
    // bit period after the previous decision, so all decisions stay centred.
`ifdef UART_RX_MAJORITY_EN
    localparam int START_DEC = OVERSAMPLE / 2;
`else
    localparam int START_DEC = OVERSAMPLE / 2 - 1;
`endif

    localparam logic [TICK_W-1:0] START_LAST = TICK_W'(START_DEC);
    localparam logic [TICK_W-1:0] BIT_LAST   = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST  = BIT_W'(STOP_BITS - 1);
    localparam logic              PAR_EN     = (PARITY_EN != 0);
    localparam logic              PAR_ODD    = (PARITY_ODD != 0);

    logic                  w_rx_s;
    logic                  w_bit;
    logic                  w_decide;
    logic                  w_stop_low_all;
    rx_state_t             r_state;
    rx_state_t             w_state_nxt;
    logic [TICK_W-1:0]     r_tick_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_par_bad;
    logic                  r_stop_low;
    logic                  r_any_high;
    logic                  r_data_write;
    logic                  r_parity_err;
    logic                  r_frame_err;
    logic                  r_overrun_err;
    logic                  r_break_det;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (rx),
        .o_sync  (w_rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // Two previous tick samples; with the current one they form the vote.
    logic [1:0] r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= 2'b11;
        end else if (sample_tick) begin
            r_hist <= {r_hist[0], w_rx_s};
        end
    end

    assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx_s) | (r_hist[0] & w_rx_s);
`else
    assign w_bit = w_rx_s;
`endif

    // A frame is bad if any stop bit, including the one being sampled now, is low.
    assign w_stop_low_all = r_stop_low | ~w_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned; a missing default would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_decide    = 1'b0;
        if (sample_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) w_state_nxt = ST_START;
                end
                ST_START: begin
                    if (r_tick_cnt == START_LAST) begin
                        w_decide    = 1'b1;
                        w_state_nxt = w_bit ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_tick_cnt == BIT_LAST) begin
                        w_decide = 1'b1;
                        if (r_bit_cnt == DATA_LAST) begin
                            w_state_nxt = PAR_EN ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (r_tick_cnt == BIT_LAST) begin
                        w_decide    = 1'b1;
                        w_state_nxt = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (r_tick_cnt == BIT_LAST) begin
                        w_decide = 1'b1;
                        if (r_bit_cnt == STOP_LAST) begin
                            // A low stop may be the start of a break: hold off
                            // new starts until the line has gone high again.
                            w_state_nxt = w_stop_low_all ? ST_WAIT_IDLE : ST_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (w_rx_s) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: the shift register and all datapath flops are reset along with the
    // FSM, so a reset mid-frame leaves no partial word behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_data_out    <= '0;
            r_par_bad     <= 1'b0;
            r_stop_low    <= 1'b0;
            r_any_high    <= 1'b0;
            r_data_write  <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
            r_break_det   <= 1'b0;
        end else begin
            r_data_write  <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
            r_break_det   <= 1'b0;

            if (sample_tick) begin
                if (w_decide || r_state == ST_IDLE || r_state == ST_WAIT_IDLE) begin
                    r_tick_cnt <= '0;
                end else begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                end

                if (w_decide) begin
                    case (r_state)
                        ST_START: begin
                            r_bit_cnt  <= '0;
                            r_par_bad  <= 1'b0;
                            r_stop_low <= 1'b0;
                            r_any_high <= 1'b0;
                        end
                        ST_DATA: begin
                            // Right shift: the first (LSB) bit ends at bit 0.
                            r_shift    <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                            r_any_high <= r_any_high | w_bit;
                            r_bit_cnt  <= (r_bit_cnt == DATA_LAST) ? '0 : r_bit_cnt + 1'b1;
                        end
                        ST_PARITY: begin
                            r_par_bad  <= w_bit ^ par_calc(9'(r_shift), PAR_ODD);
                            r_any_high <= r_any_high | w_bit;
                        end
                        ST_STOP: begin
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                            r_stop_low <= w_stop_low_all;
                            r_any_high <= r_any_high | w_bit;
                            if (r_bit_cnt == STOP_LAST) begin
                                if (!w_stop_low_all) begin
                                    // A dropped frame reports overrun only.
                                    if (fifo_full) begin
                                        r_overrun_err <= 1'b1;
                                    end else begin
                                        r_data_out   <= r_shift;
                                        r_data_write <= 1'b1;
                                        r_parity_err <= r_par_bad;
                                    end
                                end else begin
                                    r_frame_err <= 1'b1;
                                    r_break_det <= ~(r_any_high | w_bit);
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign data_out    = r_data_out;
    assign data_write  = r_data_write;
    assign rx_busy     = (r_state != ST_IDLE);
    assign parity_err  = r_parity_err;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;
    assign break_det   = r_break_det;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Two receivers share clock, reset and sample_tick:
//   lane 0 : 8N1, OVERSAMPLE 16
//   lane 1 : 8 data bits, even parity, 2 stop bits, OVERSAMPLE 16
// Each frame sent pushes the outcome predicted from the framing rules onto the
// lane's queue; a negedge monitor per lane pops and compares whenever the
// receiver raises any strobe.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int OS = 16;

    typedef struct packed {
        logic       wr;
        logic       perr;
        logic       ferr;
        logic       ovr;
        logic       brk;
        logic [7:0] dout;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_tick = 1'b0;
    logic       rx_n = 1'b1;
    logic       rx_p = 1'b1;
    logic       full_n = 1'b0;
    logic       full_p = 1'b0;
    logic [7:0] dout_n, dout_p;
    logic       wr_n, busy_n, perr_n, ferr_n, ovr_n, brk_n;
    logic       wr_p, busy_p, perr_p, ferr_p, ovr_p, brk_p;

    exp_t       q_n[$];
    exp_t       q_p[$];
    logic [7:0] last_n = 8'h00;
    logic [7:0] last_p = 8'h00;
    int         n_checks = 0;
    int         n_fail = 0;
    int         tick_div = 1;

    uart_rx #(.DATA_WIDTH(8), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0), .OVERSAMPLE(OS)) dut_n (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx(rx_n), .fifo_full(full_n),
        .data_out(dout_n), .data_write(wr_n), .rx_busy(busy_n), .parity_err(perr_n),
        .frame_err(ferr_n), .overrun_err(ovr_n), .break_det(brk_n)
    );

    uart_rx #(.DATA_WIDTH(8), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0), .OVERSAMPLE(OS)) dut_p (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx(rx_p), .fifo_full(full_p),
        .data_out(dout_p), .data_write(wr_p), .rx_busy(busy_p), .parity_err(perr_p),
        .frame_err(ferr_p), .overrun_err(ovr_p), .break_det(brk_p)
    );

    always #5 clk = ~clk;

    // Ticks are every clock (tick_div=1) or random with mean spacing tick_div.
    initial begin
        forever begin
            @(negedge clk);
            sample_tick = (tick_div <= 1) ? 1'b1 : ($urandom_range(0, tick_div - 1) == 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    // Reference outcome of one frame, from the framing rules alone.
    function automatic exp_t model(input int lane, input logic [7:0] data, input logic par_bit,
                                   input logic [1:0] stops, input logic full, input logic [7:0] last);
        exp_t e;
        logic par_on, stop_ok, stop_any_high;
        par_on        = (lane == 1);
        stop_ok       = par_on ? (stops == 2'b11) : stops[0];
        stop_any_high = par_on ? (|stops) : stops[0];
        e = '0;
        if (stop_ok) begin
            if (full) begin
                e.ovr = 1'b1;
            end else begin
                e.wr   = 1'b1;
                e.perr = par_on && (par_bit != even_par(data));
            end
        end else begin
            e.ferr = 1'b1;
            e.brk  = (data == 8'h00) && !(par_on && par_bit) && !stop_any_high;
        end
        e.dout = e.wr ? data : last;
        return e;
    endfunction

    task automatic expect_frame(input int lane, input logic [7:0] data, input logic par_bit,
                                input logic [1:0] stops, input logic full);
        exp_t e;
        if (lane == 0) begin
            e = model(0, data, par_bit, stops, full, last_n);
            q_n.push_back(e);
            last_n = e.dout;
        end else begin
            e = model(1, data, par_bit, stops, full, last_p);
            q_p.push_back(e);
            last_p = e.dout;
        end
    endtask

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (sample_tick) k++;
        end
    endtask

    task automatic drive_bit(input int lane, input logic v, input int nticks);
        @(negedge clk);
        if (lane == 0) rx_n = v;
        else           rx_p = v;
        wait_ticks(nticks);
    endtask

    task automatic set_full(input int lane, input logic v);
        @(negedge clk);
        if (lane == 0) full_n = v;
        else           full_p = v;
    endtask

    // Sends one frame and predicts its outcome. gap = idle-high ticks afterwards.
    task automatic send_frame(input int lane, input logic [7:0] data, input logic par_bit,
                              input logic [1:0] stops, input logic full, input int gap);
        expect_frame(lane, data, par_bit, stops, full);
        set_full(lane, full);
        drive_bit(lane, 1'b0, OS);
        for (int i = 0; i < 8; i++) drive_bit(lane, data[i], OS);
        if (lane == 1) drive_bit(lane, par_bit, OS);
        drive_bit(lane, stops[0], OS);
        if (lane == 1) drive_bit(lane, stops[1], OS);
        if (gap > 0) drive_bit(lane, 1'b1, gap);
        set_full(lane, 1'b0);
    endtask

    task automatic monitor_lane(input int lane, input logic wr, input logic perr, input logic ferr,
                                input logic ovr, input logic brk, input logic [7:0] dout);
        exp_t e;
        if (wr | perr | ferr | ovr | brk) begin
            if ((lane == 0 && q_n.size() == 0) || (lane == 1 && q_p.size() == 0)) begin
                n_checks++;
                n_fail++;
                $display("FAIL lane%0d unexpected strobe: wr/perr/ferr/ovr/brk=%b%b%b%b%b data_out=0x%0h, required none",
                         lane, wr, perr, ferr, ovr, brk, dout);
            end else begin
                e = (lane == 0) ? q_n.pop_front() : q_p.pop_front();
                check($sformatf("lane%0d strobes wr/perr/ferr/ovr/brk", lane),
                      32'({wr, perr, ferr, ovr, brk}), 32'({e.wr, e.perr, e.ferr, e.ovr, e.brk}));
                check($sformatf("lane%0d data_out", lane), 32'(dout), 32'(e.dout));
            end
        end
    endtask

    always @(negedge clk) if (rst_n) monitor_lane(0, wr_n, perr_n, ferr_n, ovr_n, brk_n, dout_n);
    always @(negedge clk) if (rst_n) monitor_lane(1, wr_p, perr_p, ferr_p, ovr_p, brk_p, dout_p);

    initial begin
        int budget;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset outputs lane0", 32'({dout_n, wr_n, busy_n, perr_n, ferr_n, ovr_n, brk_n}), 32'h0);
        check("reset outputs lane1", 32'({dout_p, wr_p, busy_p, perr_p, ferr_p, ovr_p, brk_p}), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: plain good frames
        tick_div = 1;
        send_frame(0, 8'hA5, 1'b0, 2'b11, 1'b0, 8);
        @(negedge clk);
        check("t1 rx_busy low after frame", 32'(busy_n), 32'h0);
        send_frame(1, 8'hA5, even_par(8'hA5), 2'b11, 1'b0, 8);

        // 2: wrong parity still writes, with parity_err
        send_frame(1, 8'h3C, 1'b1, 2'b11, 1'b0, 8);

        // 3: stop bit low, line stays low, receiver must wait for idle
        send_frame(0, 8'h55, 1'b0, 2'b00, 1'b0, 0);
        drive_bit(0, 1'b0, 2 * OS);
        @(negedge clk);
        check("t3 busy while line low after frame error", 32'(busy_n), 32'h1);
        drive_bit(0, 1'b1, OS);
        @(negedge clk);
        check("t3 idle after line high", 32'(busy_n), 32'h0);

        // 4: break on both lanes, then a normal frame
        expect_frame(0, 8'h00, 1'b0, 2'b00, 1'b0);
        drive_bit(0, 1'b0, 12 * OS);
        @(negedge clk);
        check("t4 busy during break", 32'(busy_n), 32'h1);
        drive_bit(0, 1'b1, 2 * OS);
        @(negedge clk);
        check("t4 idle after break", 32'(busy_n), 32'h0);
        send_frame(0, 8'h01, 1'b0, 2'b11, 1'b0, 8);
        expect_frame(1, 8'h00, 1'b0, 2'b00, 1'b0);
        drive_bit(1, 1'b0, 14 * OS);
        drive_bit(1, 1'b1, 2 * OS);
        send_frame(1, 8'h01, even_par(8'h01), 2'b11, 1'b0, 8);

        // 5: FIFO full drops the frame; parity error hidden by overrun
        send_frame(0, 8'hFF, 1'b0, 2'b11, 1'b1, 8);
        send_frame(1, 8'h0F, 1'b1, 2'b11, 1'b1, 8);

        // Randomized frames
        for (int i = 0; i < 40; i++) begin
            int         lane;
            logic [7:0] d;
            logic       pb;
            logic [1:0] st;
            logic       fl;
            lane     = $urandom_range(0, 1);
            tick_div = $urandom_range(1, 3);
            d        = 8'($urandom);
            pb       = even_par(d) ^ ($urandom_range(0, 3) == 0);
            st       = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
            fl       = ($urandom_range(0, 4) == 0);
            send_frame(lane, d, pb, st, fl, $urandom_range(4, 40));
        end

        // 6: short glitch is a false start
        tick_div = 1;
        drive_bit(0, 1'b1, 4);
        drive_bit(0, 1'b0, 4);
        drive_bit(0, 1'b1, 2);
        @(negedge clk);
        check("t6 glitch enters START", 32'(busy_n), 32'h1);
        wait_ticks(OS);
        @(negedge clk);
        check("t6 glitch back to idle", 32'(busy_n), 32'h0);

        // 6: reset in the middle of the data bits
        drive_bit(1, 1'b0, OS);
        for (int i = 0; i < 3; i++) drive_bit(1, i[0], OS);
        @(negedge clk);
        check("t6 busy mid-data before reset", 32'(busy_p), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t6 reset outputs lane1", 32'({dout_p, wr_p, busy_p, perr_p, ferr_p, ovr_p, brk_p}), 32'h0);
        check("t6 reset outputs lane0", 32'({dout_n, wr_n, busy_n, perr_n, ferr_n, ovr_n, brk_n}), 32'h0);
        rx_p   = 1'b1;
        last_n = 8'h00;
        last_p = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive_bit(1, 1'b1, OS);
        send_frame(1, 8'h81, even_par(8'h81), 2'b11, 1'b0, 8);
        send_frame(0, 8'h81, 1'b0, 2'b11, 1'b0, 8);

        // Drain: every predicted outcome must have been observed
        budget = 0;
        while ((q_n.size() != 0 || q_p.size() != 0) && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        check("lane0 outstanding predictions", 32'(q_n.size()), 32'h0);
        check("lane1 outstanding predictions", 32'(q_p.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
